// File: rtl/program_loader_if.sv
// Byte link into the loader plus the instruction-memory write port it drives.
// Master is the host side (byte source, memory observer); slave is the loader.
interface program_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] Instruction;
    logic        LoadInstructions;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  Instruction,
        input  LoadInstructions
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output Instruction,
        output LoadInstructions
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: byte stream -> big-endian words -> instruction memory, then a CPU reset pulse.
// Latency: 4th byte of a word accepted at t gives LoadInstructions at t+1; next byte no earlier than t+2.
// Backpressure: byte_ready drops outside COUNT/RECV/CSUM; optional checksum byte via PROGRAM_LOADER_CSUM_EN.
module program_loader #(
    parameter int MAX_WORDS  = 64,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    program_loader_if.slave  link,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       words_loaded
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, CLEAR, COUNT, RECV, WRITE, BOOT, RUN, ERROR
`ifdef PROGRAM_LOADER_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t         state, nextState;
    logic [RW-1:0]  rstCnt;
    logic [IW-1:0]  idleCnt;
    logic [1:0]     byteCnt;
    logic [7:0]     numWords;
    logic [23:0]    shiftReg;
`ifdef PROGRAM_LOADER_CSUM_EN
    logic [7:0]     csumAcc;
`endif

    logic accept, rstDone, idleExpired, startOk;

    assign accept      = link.byte_valid && link.byte_ready;
    assign rstDone     = (rstCnt == RW'(RST_CYCLES - 1));
    // RECV is only ever reached after the count byte, so the idle timer always runs there.
    assign idleExpired = !accept && (idleCnt == IW'(TIMEOUT - 1));
    assign startOk     = start && (state == IDLE || state == RUN || state == ERROR);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (start) nextState = CLEAR;
            CLEAR: if (rstDone) nextState = COUNT;
            COUNT: if (accept)
                       nextState = (link.byte_in == 8'd0 || link.byte_in > 8'(MAX_WORDS)) ? ERROR : RECV;
            RECV:  if (accept && byteCnt == 2'd3) nextState = WRITE;
                   else if (idleExpired)          nextState = ERROR;
            WRITE: if (words_loaded == numWords)
`ifdef PROGRAM_LOADER_CSUM_EN
                       nextState = CSUM;
`else
                       nextState = BOOT;
`endif
                   else
                       nextState = RECV;
`ifdef PROGRAM_LOADER_CSUM_EN
            CSUM:  if (accept) nextState = (link.byte_in == csumAcc) ? BOOT : ERROR;
`endif
            BOOT:  if (rstDone) nextState = RUN;
            RUN:   if (start) nextState = CLEAR;
            ERROR: if (start) nextState = CLEAR;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state                 <= IDLE;
            rstCnt                <= '0;
            idleCnt               <= '0;
            byteCnt               <= '0;
            numWords              <= '0;
            shiftReg              <= '0;
`ifdef PROGRAM_LOADER_CSUM_EN
            csumAcc               <= '0;
`endif
            words_loaded          <= '0;
            link.Instruction      <= '0;
            link.LoadInstructions <= 1'b0;
            link.byte_ready       <= 1'b0;
            cpu_reset             <= 1'b1;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
        end else begin
            state <= nextState;

            // Datapath follows the current state.
            if (startOk) begin
                rstCnt       <= '0;
                idleCnt      <= '0;
                byteCnt      <= '0;
                words_loaded <= '0;
`ifdef PROGRAM_LOADER_CSUM_EN
                csumAcc      <= '0;
`endif
            end
            case (state)
                CLEAR, BOOT: rstCnt <= rstDone ? '0 : rstCnt + RW'(1);
                COUNT: if (accept) begin
                    numWords <= link.byte_in;
                    idleCnt  <= '0;
                end
                RECV: if (accept) begin
                    shiftReg <= {shiftReg[15:0], link.byte_in};
                    byteCnt  <= byteCnt + 2'd1;
                    idleCnt  <= '0;
`ifdef PROGRAM_LOADER_CSUM_EN
                    csumAcc  <= csumAcc ^ link.byte_in;
`endif
                    if (byteCnt == 2'd3) begin
                        link.Instruction <= {shiftReg, link.byte_in};
                        words_loaded     <= words_loaded + 8'd1;
                    end
                end else begin
                    idleCnt <= idleCnt + IW'(1);
                end
                default: ;
            endcase

            // Outputs are registered images of the state being entered.
            link.byte_ready       <= 1'b0;
            link.LoadInstructions <= 1'b0;
            cpu_reset             <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
            case (nextState)
                IDLE:  cpu_reset <= 1'b1;
                CLEAR: begin cpu_reset <= 1'b1; busy <= 1'b1; end
                COUNT, RECV: begin link.byte_ready <= 1'b1; busy <= 1'b1; end
`ifdef PROGRAM_LOADER_CSUM_EN
                CSUM:  begin link.byte_ready <= 1'b1; busy <= 1'b1; end
`endif
                WRITE: begin link.LoadInstructions <= 1'b1; busy <= 1'b1; end
                BOOT:  begin cpu_reset <= 1'b1; busy <= 1'b1; end
                RUN:   done <= 1'b1;
                ERROR: begin cpu_reset <= 1'b1; error <= 1'b1; end
                default: cpu_reset <= 1'b1;
            endcase
        end
    end

endmodule
